// File: rtl/sad_attn_pkg.sv
// sad_attn_pkg: state encoding, derived-width helpers and the token-count clamp
// shared by sad_attn_param and its bench.
package sad_attn_pkg;

    typedef enum logic [2:0] {IDLE, IN, QKV, SC, OUT} state_t;

    function automatic int qw_f(input int dw, input int d);
        return 2 * dw + $clog2(d);
    endfunction

    function automatic int sw_f(input int qw, input int d);
        return 2 * qw + $clog2(d);
    endfunction

    function automatic int ow_f(input int sw, input int qw, input int t_max);
        return sw + qw + $clog2(t_max);
    endfunction

    function automatic int tw_f(input int t_max);
        return $clog2(t_max + 1);
    endfunction

    // Out-of-range token counts (0 or above T_MAX) run as a full T_MAX job.
    function automatic int t_clamp(input int t, input int t_max);
        return (t < 1 || t > t_max) ? t_max : t;
    endfunction

endpackage

// File: rtl/sad_cg_cell.sv
// sad_cg_cell: latch-based integrated clock gate; enable is captured while clk is low
// so gclk never glitches. Instantiated by sad_attn_param only when SAD_CG_EN is defined.
module sad_cg_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);
    logic en_l;

    always_latch begin
        if (!clk) en_l <= en;
    end

    assign gclk = clk & en_l;
endmodule

// File: rtl/sad_attn_param.sv
// sad_attn_param: serial-in/serial-out self-attention O = (X*Wq)(X*Wk)^T(X*Wv), T selectable per job.
// Define SAD_CG_EN to clock the X/W, QKV and S banks from sad_cg_cell gates controlled by cg_en.
//
// state | meaning
// IDLE  | waiting for the first in_valid of a job
// IN    | storing X and weights; first cycle with in_valid low computes Q/K/V[0][0]
// QKV   | one Q/K/V element (i,j) per cycle
// SC    | one score S[i][k] per cycle
// OUT   | one O[i][j] per cycle, registered straight to out_data
module sad_attn_param
    import sad_attn_pkg::*;
#(
    parameter int T_MAX = 8,
    parameter int D = 4,
    parameter int DW = 8,
    localparam int QW = qw_f(DW, D),
    localparam int SW = sw_f(QW, D),
    localparam int OW = ow_f(SW, QW, T_MAX),
    localparam int TW = tw_f(T_MAX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cg_en,
    input  logic                 in_valid,
    input  logic [TW-1:0]        T,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] w_Q,
    input  logic signed [DW-1:0] w_K,
    input  logic signed [DW-1:0] w_V,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data
);
    localparam int MX = (T_MAX > D) ? T_MAX : D;
    localparam int CW = $clog2(MX + 1);

    state_t state, state_nx;
    logic [TW-1:0] teff;
    logic [CW-1:0] in_r, in_c, p_r, p_c;

    logic signed [DW-1:0] x_mem  [T_MAX][D];
    logic signed [DW-1:0] wq_mem [D][D];
    logic signed [DW-1:0] wk_mem [D][D];
    logic signed [DW-1:0] wv_mem [D][D];
    logic signed [QW-1:0] q_mem  [T_MAX][D];
    logic signed [QW-1:0] k_mem  [T_MAX][D];
    logic signed [QW-1:0] v_mem  [T_MAX][D];
    logic signed [SW-1:0] s_mem  [T_MAX][T_MAX];

    logic start, we_in, qkv_act, sc_act, out_act, p_wrap, p_last;
    int t_cur, wr_r, wr_c, c_lim;
    logic signed [QW-1:0] q_new, k_new, v_new;
    logic signed [SW-1:0] s_new;
    logic signed [OW-1:0] o_new;
    logic clk_in, clk_qkv, clk_s;

    always_comb begin
        start   = (state == IDLE) && in_valid;
        we_in   = start || (state == IN && in_valid);
        qkv_act = (state == QKV) || (state == IN && !in_valid);
        sc_act  = (state == SC);
        out_act = (state == OUT);
        t_cur   = start ? t_clamp(int'(T), T_MAX) : int'(teff);
        wr_r    = start ? 0 : int'(in_r);
        wr_c    = start ? 0 : int'(in_c);
        c_lim   = sc_act ? int'(teff) : D;
        p_wrap  = (int'(p_c) == c_lim - 1);
        p_last  = p_wrap && (int'(p_r) == int'(teff) - 1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = IN;
            IN:      if (!in_valid) state_nx = p_last ? SC : QKV;
            QKV:     if (p_last) state_nx = SC;
            SC:      if (p_last) state_nx = OUT;
            OUT:     if (p_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            teff      <= '0;
            in_r      <= '0;
            in_c      <= '0;
            p_r       <= '0;
            p_c       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            if (start) teff <= TW'(t_cur);
            // Input row index saturates: rows past max(T_MAX, D) are never stored.
            if (we_in) begin
                if (wr_c == D - 1) begin
                    in_c <= '0;
                    in_r <= (wr_r < MX) ? CW'(wr_r + 1) : CW'(wr_r);
                end else begin
                    in_c <= CW'(wr_c + 1);
                    in_r <= CW'(wr_r);
                end
            end
            if (qkv_act || sc_act || out_act) begin
                if (p_last) begin
                    p_r <= '0;
                    p_c <= '0;
                end else if (p_wrap) begin
                    p_r <= p_r + CW'(1);
                    p_c <= '0;
                end else begin
                    p_c <= p_c + CW'(1);
                end
            end
            out_valid <= out_act;
            out_data  <= out_act ? o_new : '0;
        end
    end

    always_comb begin
        q_new = '0;
        k_new = '0;
        v_new = '0;
        s_new = '0;
        o_new = '0;
        for (int i = 0; i < T_MAX; i++) begin
            if (i == int'(p_r)) begin
                for (int j = 0; j < D; j++) begin
                    if (j == int'(p_c)) begin
                        for (int k = 0; k < D; k++) begin
                            q_new = q_new + QW'(x_mem[i][k]) * QW'(wq_mem[k][j]);
                            k_new = k_new + QW'(x_mem[i][k]) * QW'(wk_mem[k][j]);
                            v_new = v_new + QW'(x_mem[i][k]) * QW'(wv_mem[k][j]);
                        end
                        for (int k = 0; k < T_MAX; k++) begin
                            if (k < int'(teff)) o_new = o_new + OW'(s_mem[i][k]) * OW'(v_mem[k][j]);
                        end
                    end
                end
                for (int k = 0; k < T_MAX; k++) begin
                    if (k == int'(p_c)) begin
                        for (int j = 0; j < D; j++) s_new = s_new + SW'(q_mem[i][j]) * SW'(k_mem[k][j]);
                    end
                end
            end
        end
    end

`ifdef SAD_CG_EN
    logic en_in, en_qkv, en_s;
    assign en_in  = !cg_en || we_in;
    assign en_qkv = !cg_en || qkv_act;
    assign en_s   = !cg_en || sc_act;
    sad_cg_cell u_cg_in  (.clk(clk), .en(en_in),  .gclk(clk_in));
    sad_cg_cell u_cg_qkv (.clk(clk), .en(en_qkv), .gclk(clk_qkv));
    sad_cg_cell u_cg_s   (.clk(clk), .en(en_s),   .gclk(clk_s));
`else
    logic unused_cg;
    assign unused_cg = cg_en;
    assign clk_in    = clk;
    assign clk_qkv   = clk;
    assign clk_s     = clk;
`endif

    // X rows at or beyond this job's T are cleared on the first input cycle.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            for (int r = 0; r < T_MAX; r++) begin
                for (int c = 0; c < D; c++) begin
                    if (start && r >= t_cur) x_mem[r][c] <= '0;
                    if (r == wr_r && c == wr_c && r < t_cur) x_mem[r][c] <= in_data;
                end
            end
            for (int k = 0; k < D; k++) begin
                for (int j = 0; j < D; j++) begin
                    if (k == wr_r && j == wr_c) begin
                        wq_mem[k][j] <= w_Q;
                        wk_mem[k][j] <= w_K;
                        wv_mem[k][j] <= w_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_qkv) begin
        if (qkv_act) begin
            for (int i = 0; i < T_MAX; i++) begin
                for (int j = 0; j < D; j++) begin
                    if (i == int'(p_r) && j == int'(p_c)) begin
                        q_mem[i][j] <= q_new;
                        k_mem[i][j] <= k_new;
                        v_mem[i][j] <= v_new;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_s) begin
        if (sc_act) begin
            for (int i = 0; i < T_MAX; i++) begin
                for (int k = 0; k < T_MAX; k++) begin
                    if (i == int'(p_r) && k == int'(p_c)) s_mem[i][k] <= s_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_attn_param.sv
// tb_sad_attn_param: random and directed jobs checked against a matrix-level reference model.
module tb_sad_attn_param;
    localparam int T_MAX = 8;
    localparam int D = 4;
    localparam int DW = 8;
    localparam int TW = 4;
    localparam int OW = 59;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cg_en = 1'b0;
    logic in_valid = 1'b0;
    logic [TW-1:0] t_in = '0;
    logic signed [DW-1:0] in_data = '0, w_q = '0, w_k = '0, w_v = '0;
    logic out_valid;
    logic signed [OW-1:0] out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    longint xm [T_MAX][D];
    longint wqm [D][D], wkm [D][D], wvm [D][D];
    longint qm [T_MAX][D], km [T_MAX][D], vm [T_MAX][D];
    longint sm [T_MAX][T_MAX];
    longint om [T_MAX][D];
    longint exp_q[$];
    int start_q[$];
    int len_q[$];
    bit prev_valid = 1'b0;
    int run = 0;

    sad_attn_param dut (
        .clk(clk), .rst_n(rst_n), .cg_en(cg_en), .in_valid(in_valid), .T(t_in),
        .in_data(in_data), .w_Q(w_q), .w_K(w_k), .w_V(w_v),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input longint act);
        total++;
        bad++;
        $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Output checker: data, first-output cycle and burst length for every job.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_data", longint'(out_data), 0);
            prev_valid = 1'b0;
            run = 0;
        end else if (out_valid) begin
            if (!prev_valid) begin
                if (start_q.size() == 0) flag("start_unexpected", longint'(cyc));
                else chk("start_cycle", longint'(cyc), longint'(start_q.pop_front()));
            end
            if (exp_q.size() == 0) flag("data_unexpected", longint'(out_data));
            else chk("out_data", longint'(out_data), exp_q.pop_front());
            run++;
            prev_valid = 1'b1;
        end else begin
            chk("idle_out_data", longint'(out_data), 0);
            if (prev_valid) begin
                if (len_q.size() == 0) flag("len_unexpected", longint'(run));
                else chk("valid_length", longint'(run), longint'(len_q.pop_front()));
            end
            run = 0;
            prev_valid = 1'b0;
        end
    end

    function automatic longint rnd();
        return longint'($urandom_range(0, 255)) - 128;
    endfunction

    // mode 0: random, 1: X row0 all ones with identity weights, 2: everything -128
    task automatic fill(input int mode);
        for (int r = 0; r < T_MAX; r++)
            for (int c = 0; c < D; c++)
                xm[r][c] = (mode == 2) ? -128 : (mode == 1 && r == 0) ? 1 : rnd();
        for (int k = 0; k < D; k++)
            for (int j = 0; j < D; j++) begin
                if (mode == 2) begin
                    wqm[k][j] = -128; wkm[k][j] = -128; wvm[k][j] = -128;
                end else if (mode == 1) begin
                    wqm[k][j] = (k == j) ? 1 : 0; wkm[k][j] = wqm[k][j]; wvm[k][j] = wqm[k][j];
                end else begin
                    wqm[k][j] = rnd(); wkm[k][j] = rnd(); wvm[k][j] = rnd();
                end
            end
    endtask

    task automatic model(input int te);
        for (int i = 0; i < te; i++)
            for (int j = 0; j < D; j++) begin
                qm[i][j] = 0; km[i][j] = 0; vm[i][j] = 0;
                for (int k = 0; k < D; k++) begin
                    qm[i][j] += xm[i][k] * wqm[k][j];
                    km[i][j] += xm[i][k] * wkm[k][j];
                    vm[i][j] += xm[i][k] * wvm[k][j];
                end
            end
        for (int i = 0; i < te; i++)
            for (int k = 0; k < te; k++) begin
                sm[i][k] = 0;
                for (int j = 0; j < D; j++) sm[i][k] += qm[i][j] * km[k][j];
            end
        for (int i = 0; i < te; i++)
            for (int j = 0; j < D; j++) begin
                om[i][j] = 0;
                for (int k = 0; k < te; k++) om[i][j] += sm[i][k] * vm[k][j];
            end
    endtask

    // Called and returns at a negedge; first element is sampled on the next posedge.
    task automatic run_job(input int t_raw, input int mode);
        int te, len, c;
        te = (t_raw < 1 || t_raw > T_MAX) ? T_MAX : t_raw;
        fill(mode);
        model(te);
        for (int i = 0; i < te; i++)
            for (int j = 0; j < D; j++) exp_q.push_back(om[i][j]);
        len = (te * D > D * D) ? te * D : D * D;
        c = 0;
        for (int e = 0; e < len; e++) begin
            in_valid = 1'b1;
            t_in = (e == 0) ? TW'(t_raw) : TW'($urandom_range(0, 15));
            in_data = (e < te * D) ? DW'(xm[e / D][e % D]) : DW'($urandom);
            w_q = (e < D * D) ? DW'(wqm[e / D][e % D]) : DW'($urandom);
            w_k = (e < D * D) ? DW'(wkm[e / D][e % D]) : DW'($urandom);
            w_v = (e < D * D) ? DW'(wvm[e / D][e % D]) : DW'($urandom);
            if (e == len - 1) c = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data = '0; w_q = '0; w_k = '0; w_v = '0;
        start_q.push_back(c + te * D + te * te + 1);
        len_q.push_back(te * D);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_in_time"}, longint'(n < 3000), 1);
        if (n >= 3000) begin
            exp_q.delete(); start_q.delete(); len_q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({name, "_valid_now"}, longint'(out_valid), 0);
        chk({name, "_data_now"}, longint'(out_data), 0);
        exp_q.delete(); start_q.delete(); len_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(1, 1);
        chk("pin_identity_o00", om[0][0], 4);
        chk("pin_identity_o03", om[0][3], 4);
        drain("t1_identity");

        run_job(8, 2);
        chk("pin_neg_q", qm[5][2], 65536);
        chk("pin_neg_s", sm[3][6], 64'sd1 << 34);
        chk("pin_neg_o", om[7][3], 64'sd1 << 53);
        drain("t8_neg128");

        run_job(3, 0);
        drain("b2b_t3");
        run_job(8, 0);
        drain("b2b_t8");

        run_job(0, 0);
        drain("t0_clamp");
        run_job(15, 0);
        drain("t15_clamp");

        run_job(8, 0);
        repeat (35) @(negedge clk);
        do_reset("rst_mid_sc");
        run_job(2, 0);
        drain("after_rst_t2");

        run_job(4, 0);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_out_reached", longint'(n < 500), 1);
        repeat (3) @(negedge clk);
        do_reset("rst_mid_out");
        run_job(5, 0);
        drain("after_rst_t5");

        for (int g = 0; g < 2; g++) begin
            cg_en = g[0];
            for (int r = 0; r < 3; r++) begin
                run_job(int'($urandom_range(0, 15)), 0);
                drain("cg_random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
